// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter
// that drives the select lines of the shared 4:1 mux.
interface rr_arbiter4_if;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       busy;

   // Requester side drives req and observes the grant.
   modport master (
      output req,
      input  gnt,
      input  sel,
      input  busy
   );

   // Arbiter side owns gnt/sel/busy.
   modport slave (
      input  req,
      output gnt,
      output sel,
      output busy
   );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered one-hot grant, mux select and an
// optional hold limit that preempts a long-running owner when others are waiting.
module rr_arbiter4 #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_arbiter4_if.slave bus
);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
   localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       last_q, last_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] hold_q, hold_d;

   logic [3:0]       req_other;
   logic             win_found;
   logic [1:0]       win_idx;

   // Masking the current owner serves every case at once: in IDLE gnt is zero,
   // on release the owner's request is already low, and on preemption the owner
   // must be skipped. The pointer always equals the owner while granting.
   assign req_other = bus.req & ~gnt_q;

   // Scan last+1, last+2, last+3, last; iterating backwards lets the earliest
   // position in the scan overwrite later ones.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_q;
      for (int k = 4; k >= 1; k--) begin
         if (req_other[last_q + 2'(k)]) begin
            win_found = 1'b1;
            win_idx   = last_q + 2'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         last_q  <= 2'd3;
         busy_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
      end
   end

   // Release takes priority over preemption, which takes priority over keeping.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      last_d  = last_q;
      busy_d  = busy_q;
      hold_d  = hold_q;

      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << win_idx;
               sel_d   = win_idx;
               last_d  = win_idx;
               busy_d  = 1'b1;
               hold_d  = HOLD_ONE;
            end
         end

         GRANT: begin
            if (!bus.req[sel_q]) begin
               if (win_found) begin
                  gnt_d  = 4'b0001 << win_idx;
                  sel_d  = win_idx;
                  last_d = win_idx;
                  hold_d = HOLD_ONE;
               end else begin
                  state_d = IDLE;
                  gnt_d   = 4'b0000;
                  busy_d  = 1'b0;
                  hold_d  = '0;
               end
            end else if ((MAX_HOLD != 0) && (hold_q == HOLD_LIM) && win_found) begin
               gnt_d  = 4'b0001 << win_idx;
               sel_d  = win_idx;
               last_d = win_idx;
               hold_d = HOLD_ONE;
            end else if (hold_q != HOLD_SAT) begin
               hold_d = hold_q + HOLD_ONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.gnt  = gnt_q;
   assign bus.sel  = sel_q;
   assign bus.busy = busy_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus random request
// traffic compared against a behavioural round-robin model.
module tb_rr_arbiter4;

   localparam int MAX_HOLD_TB = 4;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   // Reference model: owner index (-1 when idle), last select, pointer, cycles held.
   int   m_owner;
   int   m_sel;
   int   m_last;
   int   m_hold;

   rr_arbiter4_if bus ();

   rr_arbiter4 #(
      .MAX_HOLD (MAX_HOLD_TB),
      .CNT_W    (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_owner = -1;
      m_sel   = 0;
      m_last  = 3;
      m_hold  = 0;
   endtask

   // One arbitration decision from the rules, using an unbounded hold count.
   task automatic model_step(input logic [3:0] r);
      logic [3:0] cand;
      bit         keep;
      int         w;
      keep = 1'b0;
      cand = r;
      if (m_owner >= 0) begin
         cand[m_owner] = 1'b0;
         if (r[m_owner])
            keep = !((MAX_HOLD_TB != 0) && (m_hold >= MAX_HOLD_TB) && (cand != 4'b0000));
      end
      if (keep) begin
         m_hold++;
      end else begin
         w = -1;
         for (int k = 1; k <= 4; k++) begin
            if (w < 0 && cand[(m_last + k) % 4]) w = (m_last + k) % 4;
         end
         if (w >= 0) begin
            m_owner = w;
            m_sel   = w;
            m_last  = w;
            m_hold  = 1;
         end else begin
            m_owner = -1;
            m_hold  = 0;
         end
      end
   endtask

   function automatic logic [3:0] model_gnt();
      logic [3:0] g;
      g = 4'b0000;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   // Drive a request vector, let one edge pass, leave time parked 1ns after it.
   task automatic drive_cycle(input logic [3:0] r);
      bus.req = r;
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   task automatic do_reset();
      bus.req = 4'b0000;
      rst_n   = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.req = 4'b0000;
      rst_n   = 1'b0;
      model_reset();
      #2;
      n_checks++;
      if (bus.gnt !== 4'b0000) begin
         n_fail++;
         $display("[TB] FAIL reset_gnt got=%b want=0000", bus.gnt);
      end
      n_checks++;
      if (bus.sel !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL reset_sel got=%b want=00", bus.sel);
      end
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_busy got=%b want=0", bus.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         drive_cycle(4'b0000);
         n_checks++;
         if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_hold cycle=%0d got gnt=%b sel=%b busy=%b want 0000/00/0",
                     i, bus.gnt, bus.sel, bus.busy);
         end
      end
   endtask

   task automatic test_single();
      do_reset();
      drive_cycle(4'b0100);
      n_checks++;
      if (bus.gnt !== 4'b0100 || bus.sel !== 2'b10 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL single_grant got gnt=%b sel=%b busy=%b want 0100/10/1",
                  bus.gnt, bus.sel, bus.busy);
      end
      drive_cycle(4'b0000);
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.sel !== 2'b10 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL single_release got gnt=%b sel=%b busy=%b want 0000/10/0",
                  bus.gnt, bus.sel, bus.busy);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] reqs  [5];
      logic [3:0] order [5];
      reqs  = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_cycle(reqs[i]);
         n_checks++;
         if (bus.gnt !== order[i] || bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL rr_order step=%0d got gnt=%b busy=%b want gnt=%b busy=1",
                     i, bus.gnt, bus.busy, order[i]);
         end
      end
   endtask

   task automatic test_preempt();
      do_reset();
      drive_cycle(4'b0001);
      n_checks++;
      if (bus.gnt !== 4'b0001) begin
         n_fail++;
         $display("[TB] FAIL preempt_first got=%b want=0001", bus.gnt);
      end
      for (int i = 0; i < 3; i++) begin
         drive_cycle(4'b0011);
         n_checks++;
         if (bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL preempt_hold cycle=%0d got=%b want=0001", i + 2, bus.gnt);
         end
      end
      drive_cycle(4'b0011);
      n_checks++;
      if (bus.gnt !== 4'b0010 || bus.sel !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL preempt_switch got gnt=%b sel=%b want 0010/01", bus.gnt, bus.sel);
      end
      drive_cycle(4'b0001);
      n_checks++;
      if (bus.gnt !== 4'b0001 || bus.sel !== 2'b00 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL preempt_return got gnt=%b sel=%b busy=%b want 0001/00/1",
                  bus.gnt, bus.sel, bus.busy);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive_cycle(4'b1000);
         n_checks++;
         if (bus.gnt !== 4'b1000 || bus.sel !== 2'b11 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL saturate cycle=%0d got gnt=%b sel=%b busy=%b want 1000/11/1",
                     i, bus.gnt, bus.sel, bus.busy);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      drive_cycle(4'b0100);
      drive_cycle(4'b0010);
      n_checks++;
      if (bus.gnt !== 4'b0010) begin
         n_fail++;
         $display("[TB] FAIL midrst_setup got=%b want=0010", bus.gnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if (bus.gnt !== 4'b0000 || bus.sel !== 2'b00 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midrst_async got gnt=%b sel=%b busy=%b want 0000/00/0",
                  bus.gnt, bus.sel, bus.busy);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive_cycle(4'b1010);
      n_checks++;
      if (bus.gnt !== 4'b0010 || bus.sel !== 2'b01) begin
         n_fail++;
         $display("[TB] FAIL midrst_priority got gnt=%b sel=%b want 0010/01", bus.gnt, bus.sel);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      do_reset();
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
         end
         drive_cycle(r);
         n_checks++;
         if (bus.gnt !== model_gnt() || bus.sel !== 2'(m_sel) || bus.busy !== (m_owner >= 0)) begin
            n_fail++;
            $display("[TB] FAIL random cycle=%0d req=%b got gnt=%b sel=%b busy=%b want gnt=%b sel=%0d busy=%0d",
                     i, r, bus.gnt, bus.sel, bus.busy, model_gnt(), m_sel, (m_owner >= 0));
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus.req  = 4'b0000;
      rst_n    = 1'b0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_preempt();
      test_saturation();
      test_reset_mid_grant();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
